// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Wait counter width; covers the legal WAIT range 1..15.
    localparam int unsigned CNT_W = 4;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_AUX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the two-port memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          req1;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, gnt, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, gnt, mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. MEM_ARB_RR_EN selects round-robin on ties;
// otherwise port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic any_req,
    output logic winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_served;
        end else begin
            winner = req1 ? PORT_AUX : PORT_CPU;
        end
    end
`else
    logic unused_last_served;
    assign unused_last_served = last_served;

    always_comb begin
        any_req = req0 | req1;
        winner  = req0 ? PORT_CPU : PORT_AUX;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one WAIT-cycle access per grant, then a one-cycle ack.
// Build with MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW   = 13,
    parameter int unsigned DW   = 8,
    parameter int unsigned WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(WAIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             last_served;
    logic             any_req;
    logic             winner;

    mem_arb_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_served (last_served),
        .any_req     (any_req),
        .winner      (winner)
    );

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // Resets to the aux port so the first tie after reset goes to the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_AUX;
        end else if (state_q == StIdle && any_req) begin
            last_q <= winner;
        end
    end

    assign last_served = last_q;
`else
    assign last_served = PORT_AUX;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                    cnt_d   = WaitLoad;
                    gnt_d   = port_onehot(winner);
                    wr_d    = (winner == PORT_AUX) ? bus.wr1    : bus.wr0;
                    addr_d  = (winner == PORT_AUX) ? bus.addr1  : bus.addr0;
                    wdata_d = (winner == PORT_AUX) ? bus.wdata1 : bus.wdata0;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!wr_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.mem_rd    = (state_q == StAccess) && !wr_q;
    assign bus.mem_wr    = (state_q == StAccess) && wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.ack0      = (state_q == StDone) && gnt_q[0];
    assign bus.ack1      = (state_q == StDone) && gnt_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random traffic against
// a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned AW   = 13;
    localparam int unsigned DW   = 8;
    localparam int unsigned WAIT = 2;
    localparam int unsigned MEMN = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   checking_en = 1'b0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h86;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory the DUT talks to; unwritten locations read as fill(addr).
    bit [DW-1:0] phys_mem   [MEMN];
    bit          phys_valid [MEMN];

    assign bus.mem_rdata = phys_valid[bus.mem_addr] ? phys_mem[bus.mem_addr] : fill(bus.mem_addr);

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            phys_mem[bus.mem_addr]   <= bus.mem_wdata;
            phys_valid[bus.mem_addr] <= 1'b1;
        end
    end

    // Reference model: phase = cycles since the grant edge (0 = idle),
    // strobes in phases 1..WAIT, ack in phase WAIT+1.
    int unsigned   phase;
    logic          m_owner, m_wr, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    bit [DW-1:0]   ref_mem   [MEMN];
    bit            ref_valid [MEMN];

    function automatic logic ref_pick(input logic r0, input logic r1, input logic last);
`ifdef MEM_ARB_RR_EN
        if (r0 && r1) return ~last;
`endif
        return r0 ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= 0;
            m_owner <= 1'b0;
            m_wr    <= 1'b0;
            m_last  <= 1'b1;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else if (phase == 0) begin
            if (bus.req0 || bus.req1) begin
                m_owner <= ref_pick(bus.req0, bus.req1, m_last);
                m_last  <= ref_pick(bus.req0, bus.req1, m_last);
                m_wr    <= ref_pick(bus.req0, bus.req1, m_last) ? bus.wr1 : bus.wr0;
                m_addr  <= ref_pick(bus.req0, bus.req1, m_last) ? bus.addr1 : bus.addr0;
                m_wdata <= ref_pick(bus.req0, bus.req1, m_last) ? bus.wdata1 : bus.wdata0;
                phase   <= 1;
            end
        end else if (phase == WAIT + 1) begin
            phase <= 0;
        end else begin
            if (phase == WAIT) begin
                if (m_wr) begin
                    ref_mem[m_addr]   <= m_wdata;
                    ref_valid[m_addr] <= 1'b1;
                end else begin
                    m_rdata <= ref_valid[m_addr] ? ref_mem[m_addr] : fill(m_addr);
                end
            end
            phase <= phase + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic       strobe;
        logic [1:0] exp_gnt;
        if (checking_en) begin
            strobe  = (phase >= 1) && (phase <= WAIT);
            exp_gnt = (phase == 0) ? 2'b00 : (m_owner ? 2'b10 : 2'b01);
            chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
            chk("mem_rd", 32'(bus.mem_rd), 32'(strobe && !m_wr));
            chk("mem_wr", 32'(bus.mem_wr), 32'(strobe && m_wr));
            if (strobe) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                if (m_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
            end
            chk("ack0", 32'(bus.ack0), 32'(phase == WAIT + 1 && !m_owner));
            chk("ack1", 32'(bus.ack1), 32'(phase == WAIT + 1 && m_owner));
            chk("rdata", 32'(bus.rdata), 32'(m_rdata));
            chk("rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
            chk("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        end
    end

    task automatic wait_ack(output int port);
        port = -1;
        for (int n = 0; n < 20 && port < 0; n++) begin
            @(negedge clk);
            if (bus.ack0) port = 0;
            else if (bus.ack1) port = 1;
        end
        if (port < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p;
        int nwr, na0, na1;
        int order [4];
        bit pend [2];

        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        checking_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // CPU read of 0x0123 (memory holds 0xA5 there).
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 13'h0123;
        @(negedge clk);
        chk("t1_rd_c1", 32'(bus.mem_rd), 32'd1);
        chk("t1_addr_c1", 32'(bus.mem_addr), 32'h0123);
        chk("t1_gnt_c1", 32'(bus.gnt), 32'b01);
        @(negedge clk);
        chk("t1_rd_c2", 32'(bus.mem_rd), 32'd1);
        chk("t1_gnt_c2", 32'(bus.gnt), 32'b01);
        @(negedge clk);
        chk("t1_ack0_c3", 32'(bus.ack0), 32'd1);
        chk("t1_rdata_c3", 32'(bus.rdata), 32'hA5);
        chk("t1_gnt_c3", 32'(bus.gnt), 32'b01);
        chk("t1_rd_c3", 32'(bus.mem_rd), 32'd0);
        bus.req0 = 0;
        @(negedge clk);
        chk("t1_gnt_c4", 32'(bus.gnt), 32'd0);

        // Aux write 0x3C to 0x1FFF.
        bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 13'h1FFF; bus.wdata1 = 8'h3C;
        nwr = 0; na0 = 0; na1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                nwr++;
                chk("t2_addr", 32'(bus.mem_addr), 32'h1FFF);
                chk("t2_wdata", 32'(bus.mem_wdata), 32'h3C);
            end
            na0 += int'(bus.ack0);
            if (bus.ack1) begin
                na1++;
                bus.req1 = 0;
            end
        end
        chk("t2_wr_cycles", 32'(nwr), 32'd2);
        chk("t2_ack1_count", 32'(na1), 32'd1);
        chk("t2_ack0_count", 32'(na0), 32'd0);

        // Read back the written location through the CPU port.
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 13'h1FFF;
        wait_ack(p);
        chk("t2b_port", 32'(p), 32'd0);
        chk("t2b_rdata", 32'(bus.rdata), 32'h3C);
        bus.req0 = 0;
        @(negedge clk);

        // Request dropped after the grant still completes.
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 13'h0005;
        @(negedge clk);
        bus.req0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_ack0_c3", 32'(bus.ack0), 32'd1);
        chk("t3_rdata_c3", 32'(bus.rdata), 32'h83);
        @(negedge clk);
        chk("t3_gnt_c4", 32'(bus.gnt), 32'd0);
        chk("t3_ack0_c4", 32'(bus.ack0), 32'd0);

        // Reset in the second access cycle abandons the transfer.
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 13'h0123;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_gnt", 32'(bus.gnt), 32'd0);
        chk("t5_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t5_rdata", 32'(bus.rdata), 32'd0);
        chk("t5_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        bus.req0 = 0;
        @(negedge clk);
        rst = 1'b0;
        na0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            na0 += int'(bus.ack0 | bus.ack1);
        end
        chk("t5_no_ack", 32'(na0), 32'd0);
        bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 13'h0040;
        wait_ack(p);
        chk("t5_port", 32'(p), 32'd1);
        chk("t5_rdata_after", 32'(bus.rdata), 32'hC6);
        bus.req1 = 0;
        @(negedge clk);

        // Both ports held for four accesses from a fresh reset.
        pulse_reset();
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 13'h0010;
        bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 13'h0011;
        for (int i = 0; i < 4; i++) begin
            wait_ack(p);
            order[i] = p;
        end
        bus.req0 = 0; bus.req1 = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("t4_grant%0d", i), 32'(order[i]), 32'(i % 2));
`else
            chk($sformatf("t4_grant%0d", i), 32'(order[i]), 32'd0);
`endif
        end
        @(negedge clk);

        // Random traffic on both ports.
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                logic ackq;
                logic go;
                ackq = (q == 0) ? bus.ack0 : bus.ack1;
                go = 1'b0;
                if (ackq) begin
                    pend[q] = 0;
                    go = ($urandom_range(0, 1) == 1);
                end else if (!pend[q]) begin
                    go = ($urandom_range(0, 3) == 0);
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[q] = 0;
                end
                if (go) pend[q] = 1;
                if (q == 0) begin
                    bus.req0 = pend[0];
                    if (go) begin
                        bus.wr0    = $urandom_range(0, 1) == 1;
                        bus.addr0  = AW'($urandom_range(0, 31));
                        bus.wdata0 = DW'($urandom);
                    end
                end else begin
                    bus.req1 = pend[1];
                    if (go) begin
                        bus.wr1    = $urandom_range(0, 1) == 1;
                        bus.addr1  = AW'($urandom_range(0, 31));
                        bus.wdata1 = DW'($urandom);
                    end
                end
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 13, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter WAIT, default 2, memory access cycles per transfer; legal 1..15.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Ports req0/req1  input  1 each  access request, port 0 = CPU, port 1 = loader/debug.
REQ-007 Ports wr0/wr1  input  1 each  1 = write, 0 = read.
REQ-008 Ports addr0/addr1  input  AW each  request address; wdata0/wdata1  input  DW each  write data.
REQ-009 Ports ack0/ack1  output  1 each  one-cycle completion pulse.
REQ-010 Port rdata  output  DW  read data shared by both ports, valid while ack is high.
REQ-011 Port gnt  output  2  one-hot current owner; 00 when idle.
REQ-012 Ports mem_rd, mem_wr  output  1 each; mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW.

Function
REQ-013 FSM states: IDLE, ACCESS, DONE.
REQ-014 IDLE: if any req is high at an edge, register winner's wr/addr/wdata, set gnt, load wait counter with WAIT-1, go to ACCESS; else remain in IDLE.
REQ-015 ACCESS: mem_rd = !wr_latched, mem_wr = wr_latched, mem_addr/mem_wdata from latched values, for exactly WAIT cycles; counter decrements each cycle; at 0, go to DONE.
REQ-016 Read data: mem_rdata sampled on the last ACCESS edge into rdata register.
REQ-017 DONE: ack of granted port = 1 for exactly one cycle, mem_rd = mem_wr = 0; next state IDLE; gnt clears on leaving DONE.
REQ-018 Latency: req sampled at edge k -> mem strobe cycles k+1..k+WAIT -> ack in cycle k+WAIT+1; throughput one access per WAIT+2 cycles per port.
REQ-019 Requester holds req and operands stable until ack; req still high in IDLE after ack starts a new access (back-to-back).
REQ-020 req dropped mid-access: access completes and ack still pulses; no abort.
REQ-021 Requests arriving during ACCESS/DONE are not sampled until IDLE.
REQ-022 mem_rd and mem_wr never high simultaneously; ack0 and ack1 never high simultaneously.
REQ-023 rdata holds its last value outside DONE; written value on write cycles is don't-care but unchanged.

Reset
REQ-024 reset high forces asynchronously: state IDLE, gnt = 00, ack0 = ack1 = 0, mem_rd = mem_wr = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, counter = 0, last-served = 1.
REQ-025 Reset mid-access abandons the transfer; no ack is issued; first request after release is arbitrated fresh.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous req0/req1 in IDLE, grant the port not served last; last-served updates on each grant.
REQ-027 MEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; port 1 may starve; last-served register not implemented.

Structure
REQ-028 Package mem_arb_pkg holds the state encoding (IDLE/ACCESS/DONE) and port-index constants PORT_CPU = 0, PORT_AUX = 1.
REQ-029 One sub-module mem_arb_pick: combinational winner selection from req0, req1, last-served; honours MEM_ARB_RR_EN.

Verification (WAIT = 2)
REQ-030 req0 read addr 0x0123 at edge 0, mem_rdata = 0xA5 -> mem_rd high cycles 1-2 with mem_addr 0x0123, ack0 and rdata = 0xA5 in cycle 3, gnt = 01 cycles 1-3.
REQ-031 req1 write addr 0x1FFF data 0x3C -> mem_wr high 2 cycles with mem_addr 0x1FFF, mem_wdata 0x3C, ack1 one cycle, ack0 never.
REQ-032 req0 and req1 held high 4 accesses: RR build -> grants 0,1,0,1; fixed build -> grants 0,0,0,0, ack1 never.
REQ-033 req0 high, dropped in cycle 1 -> access still completes, ack0 in cycle 3, FSM returns IDLE in cycle 4.
REQ-034 reset asserted in cycle 2 of an access -> all outputs 0 immediately, no ack; after release req1 read completes normally.
REQ-035 All runs: assertion checks mem_rd&mem_wr == 0, ack0&ack1 == 0, gnt one-hot or zero.
